// File: rtl/cursor_controller.sv
// Cursor position and drawing-colour controller: five debounced button levels in,
// registered cursor_x/cursor_y/current_color/moved out. Optional macro CURSOR_WRAP_EN wraps instead of clamping.
module cursor_controller #(
  parameter int WIDTH         = 640,
  parameter int HEIGHT        = 480,
  parameter int INIT_X        = 0,
  parameter int INIT_Y        = 0,
  parameter int NUM_COLORS    = 4,
  parameter int REPEAT_DELAY  = 25000000,
  parameter int REPEAT_PERIOD = 5000000,
  localparam int XW           = $clog2(WIDTH),
  localparam int YW           = $clog2(HEIGHT),
  localparam int COLOR_WIDTH  = $clog2(NUM_COLORS)
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   btn_up,
  input  logic                   btn_down,
  input  logic                   btn_left,
  input  logic                   btn_right,
  input  logic                   btn_color,
  output logic [XW-1:0]          cursor_x,
  output logic [YW-1:0]          cursor_y,
  output logic [COLOR_WIDTH-1:0] current_color,
  output logic                   moved
);

  localparam int MAX_REP = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int CNTW    = $clog2(MAX_REP + 1);
  localparam int XS      = XW + 1;
  localparam int YS      = YW + 1;

  localparam logic [CNTW-1:0]        DELAY_LAST  = CNTW'(REPEAT_DELAY - 1);
  localparam logic [CNTW-1:0]        PERIOD_LAST = CNTW'(REPEAT_PERIOD - 1);
  localparam logic [CNTW-1:0]        CNT_ONE     = CNTW'(1);
  localparam logic signed [XS-1:0]   X_MAX       = XS'(WIDTH - 2);
  localparam logic signed [YS-1:0]   Y_MAX       = YS'(HEIGHT - 2);
  localparam logic signed [XS-1:0]   X_STEP_POS  = XS'(1);
  localparam logic signed [XS-1:0]   X_STEP_NEG  = XS'(-1);
  localparam logic signed [YS-1:0]   Y_STEP_POS  = YS'(1);
  localparam logic signed [YS-1:0]   Y_STEP_NEG  = YS'(-1);
  localparam logic [XW-1:0]          X_INIT      = XW'(INIT_X);
  localparam logic [YW-1:0]          Y_INIT      = YW'(INIT_Y);
  localparam logic [XW-1:0]          X_TOP       = XW'(WIDTH - 2);
  localparam logic [YW-1:0]          Y_TOP       = YW'(HEIGHT - 2);
  localparam logic [COLOR_WIDTH-1:0] COLOR_FIRST = COLOR_WIDTH'(1);
  localparam logic [COLOR_WIDTH-1:0] COLOR_LAST  = COLOR_WIDTH'(NUM_COLORS - 1);
  localparam logic [COLOR_WIDTH-1:0] COLOR_ONE   = COLOR_WIDTH'(1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_DELAY  = 2'd1,
    ST_REPEAT = 2'd2
  } state_t;

  state_t                   state_r, state_nxt_s;
  logic [CNTW-1:0]          cnt_r, cnt_nxt_s;
  logic [3:0]               dir_s, dprev_r;
  logic                     step_s;
  logic signed [XS-1:0]     dx_s, x_sum_s;
  logic signed [YS-1:0]     dy_s, y_sum_s;
  logic [XW-1:0]            x_lim_s, x_nxt_s;
  logic [YW-1:0]            y_lim_s, y_nxt_s;
  logic                     chg_s, chg_r;
  logic                     color_prev_r, color_rise_s;
  logic [COLOR_WIDTH-1:0]   color_nxt_s;

  assign dir_s        = {btn_up, btn_down, btn_left, btn_right};
  assign color_rise_s = btn_color & ~color_prev_r;

  // Auto-repeat FSM: a new or changed combination steps at once, holding steps on the delay/period schedule.
  always_comb begin
    state_nxt_s = state_r;
    cnt_nxt_s   = cnt_r;
    step_s      = 1'b0;
    if (dir_s == 4'b0000) begin
      state_nxt_s = ST_IDLE;
      cnt_nxt_s   = '0;
    end else if (dir_s != dprev_r) begin
      step_s      = 1'b1;
      state_nxt_s = ST_DELAY;
      cnt_nxt_s   = '0;
    end else begin
      case (state_r)
        ST_DELAY: begin
          if (cnt_r == DELAY_LAST) begin
            step_s      = 1'b1;
            state_nxt_s = ST_REPEAT;
            cnt_nxt_s   = '0;
          end else begin
            cnt_nxt_s = cnt_r + CNT_ONE;
          end
        end
        ST_REPEAT: begin
          if (cnt_r == PERIOD_LAST) begin
            step_s    = 1'b1;
            cnt_nxt_s = '0;
          end else begin
            cnt_nxt_s = cnt_r + CNT_ONE;
          end
        end
        default: begin
          // held combination with no timing context: restart the delay without stepping
          state_nxt_s = ST_DELAY;
          cnt_nxt_s   = '0;
        end
      endcase
    end
  end

  // Step direction and bounded next position, computed one bit wider and signed so it cannot wrap silently.
  always_comb begin
    case ({btn_left, btn_right})
      2'b10:   dx_s = X_STEP_NEG;
      2'b01:   dx_s = X_STEP_POS;
      default: dx_s = '0;
    endcase
    case ({btn_up, btn_down})
      2'b10:   dy_s = Y_STEP_NEG;
      2'b01:   dy_s = Y_STEP_POS;
      default: dy_s = '0;
    endcase
    x_sum_s = $signed({1'b0, cursor_x}) + dx_s;
    y_sum_s = $signed({1'b0, cursor_y}) + dy_s;
`ifdef CURSOR_WRAP_EN
    if (x_sum_s[XS-1]) begin
      x_lim_s = X_TOP;
    end else if (x_sum_s > X_MAX) begin
      x_lim_s = '0;
    end else begin
      x_lim_s = x_sum_s[XW-1:0];
    end
    if (y_sum_s[YS-1]) begin
      y_lim_s = Y_TOP;
    end else if (y_sum_s > Y_MAX) begin
      y_lim_s = '0;
    end else begin
      y_lim_s = y_sum_s[YW-1:0];
    end
`else
    if (x_sum_s[XS-1]) begin
      x_lim_s = '0;
    end else if (x_sum_s > X_MAX) begin
      x_lim_s = X_TOP;
    end else begin
      x_lim_s = x_sum_s[XW-1:0];
    end
    if (y_sum_s[YS-1]) begin
      y_lim_s = '0;
    end else if (y_sum_s > Y_MAX) begin
      y_lim_s = Y_TOP;
    end else begin
      y_lim_s = y_sum_s[YW-1:0];
    end
`endif
    if (step_s) begin
      x_nxt_s = x_lim_s;
      y_nxt_s = y_lim_s;
    end else begin
      x_nxt_s = cursor_x;
      y_nxt_s = cursor_y;
    end
`ifdef CURSOR_WRAP_EN
    chg_s = step_s;
`else
    chg_s = (x_nxt_s != cursor_x) || (y_nxt_s != cursor_y);
`endif
  end

  // Colour advance on btn_color rising edge; any illegal code recovers to the first drawable colour.
  always_comb begin
    if ((current_color == '0) || (current_color > COLOR_LAST)) begin
      color_nxt_s = COLOR_FIRST;
    end else if (color_rise_s) begin
      if (current_color == COLOR_LAST) begin
        color_nxt_s = COLOR_FIRST;
      end else begin
        color_nxt_s = current_color + COLOR_ONE;
      end
    end else begin
      color_nxt_s = current_color;
    end
  end

  // State, position, colour and moved registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r       <= ST_IDLE;
      cnt_r         <= '0;
      dprev_r       <= 4'b0000;
      cursor_x      <= X_INIT;
      cursor_y      <= Y_INIT;
      chg_r         <= 1'b0;
      moved         <= 1'b0;
      color_prev_r  <= 1'b0;
      current_color <= COLOR_FIRST;
    end else begin
      state_r       <= state_nxt_s;
      cnt_r         <= cnt_nxt_s;
      dprev_r       <= dir_s;
      cursor_x      <= x_nxt_s;
      cursor_y      <= y_nxt_s;
      chg_r         <= chg_s;
      moved         <= chg_r;
      color_prev_r  <= btn_color;
      current_color <= color_nxt_s;
    end
  end

endmodule

// File: tb/tb_cursor_controller.sv
// Directed-vector bench for cursor_controller (WIDTH=HEIGHT=8, NUM_COLORS=4, REPEAT_DELAY=4, REPEAT_PERIOD=2).
module tb_cursor_controller;

  localparam int WIDTH = 8;
  localparam int HEIGHT = 8;
  localparam int NUM_COLORS = 4;

  localparam logic [4:0] B_UP    = 5'b10000;
  localparam logic [4:0] B_DOWN  = 5'b01000;
  localparam logic [4:0] B_LEFT  = 5'b00100;
  localparam logic [4:0] B_RIGHT = 5'b00010;
  localparam logic [4:0] B_COLOR = 5'b00001;
  localparam logic [4:0] B_NONE  = 5'b00000;

  logic clk = 1'b0;
  logic reset;
  logic btn_up, btn_down, btn_left, btn_right, btn_color;
  logic [2:0] cursor_x, cursor_y;
  logic [1:0] current_color;
  logic moved;

  int n_vec = 0;
  int n_err = 0;

  int exp_down[10] = '{1, 1, 1, 1, 2, 2, 3, 3, 4, 4};
  int exp_color[4] = '{2, 3, 1, 2};
  int exp_rep_x[5] = '{3, 3, 3, 3, 4};
`ifdef CURSOR_WRAP_EN
  int exp_hold_x[8] = '{6, 6, 6, 6, 0, 0, 1, 1};
  int exp_hold_m[8] = '{0, 1, 0, 0, 0, 1, 0, 1};
  localparam int EXP_LEFT_AT0 = 6;
  localparam int EXP_MOVED_AT0 = 1;
  localparam int N_TAPS = 6;
`else
  int exp_hold_x[8] = '{6, 6, 6, 6, 6, 6, 6, 6};
  int exp_hold_m[8] = '{0, 1, 0, 0, 0, 0, 0, 0};
  localparam int EXP_LEFT_AT0 = 0;
  localparam int EXP_MOVED_AT0 = 0;
  localparam int N_TAPS = 5;
`endif

  cursor_controller #(
    .WIDTH(WIDTH), .HEIGHT(HEIGHT), .INIT_X(0), .INIT_Y(0),
    .NUM_COLORS(NUM_COLORS), .REPEAT_DELAY(4), .REPEAT_PERIOD(2)
  ) dut (
    .clk(clk), .reset(reset),
    .btn_up(btn_up), .btn_down(btn_down), .btn_left(btn_left),
    .btn_right(btn_right), .btn_color(btn_color),
    .cursor_x(cursor_x), .cursor_y(cursor_y),
    .current_color(current_color), .moved(moved)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_btns(input logic [4:0] b);
    {btn_up, btn_down, btn_left, btn_right, btn_color} = b;
  endtask

  task automatic tap(input logic [4:0] b);
    set_btns(b);
    @(negedge clk);
    set_btns(B_NONE);
    @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    set_btns(B_NONE);
    repeat (2) @(negedge clk);
    check_eq("rst_x", cursor_x, 0);
    check_eq("rst_y", cursor_y, 0);
    check_eq("rst_color", current_color, 1);
    check_eq("rst_moved", moved, 0);
    reset = 1'b0;
    @(negedge clk);

    // single-cycle right press
    set_btns(B_RIGHT);
    @(negedge clk);
    check_eq("t1_x", cursor_x, 1);
    check_eq("t1_moved_early", moved, 0);
    set_btns(B_NONE);
    @(negedge clk);
    check_eq("t1_moved", moved, 1);
    @(negedge clk);
    check_eq("t1_moved_clear", moved, 0);
    repeat (3) @(negedge clk);
    check_eq("t1_x_hold", cursor_x, 1);

    // down held 10 cycles: steps at N, N+4, N+6, N+8
    set_btns(B_DOWN);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_eq($sformatf("t2_y[%0d]", i), cursor_y, exp_down[i]);
    end
    set_btns(B_NONE);
    repeat (3) @(negedge clk);
    check_eq("t2_y_final", cursor_y, 4);

    // left edge
    set_btns(B_LEFT);
    @(negedge clk);
    check_eq("t3_x_to0", cursor_x, 0);
    set_btns(B_NONE);
    @(negedge clk);
    check_eq("t3_moved_to0", moved, 1);
    set_btns(B_LEFT);
    @(negedge clk);
    check_eq("t3_x_left_at0", cursor_x, EXP_LEFT_AT0);
    set_btns(B_NONE);
    @(negedge clk);
    check_eq("t3_moved_left_at0", moved, EXP_MOVED_AT0);
    repeat (N_TAPS) tap(B_RIGHT);
    check_eq("t3_x_at5", cursor_x, 5);

    // right held from 5: right edge
    set_btns(B_RIGHT);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check_eq($sformatf("t3_hold_x[%0d]", i), cursor_x, exp_hold_x[i]);
      check_eq($sformatf("t3_hold_moved[%0d]", i), moved, exp_hold_m[i]);
    end
    set_btns(B_NONE);
    @(negedge clk);
`ifdef CURSOR_WRAP_EN
    tap(B_RIGHT);
`else
    repeat (4) tap(B_LEFT);
`endif
    repeat (2) tap(B_UP);
    check_eq("t4_x_pre", cursor_x, 2);
    check_eq("t4_y_pre", cursor_y, 2);

    // up+down cancel, right steps
    set_btns(B_UP | B_DOWN | B_RIGHT);
    @(negedge clk);
    check_eq("t4_x", cursor_x, 3);
    check_eq("t4_y", cursor_y, 2);
    set_btns(B_NONE);
    @(negedge clk);
    check_eq("t4_moved", moved, 1);

    // colour pulses
    for (int i = 0; i < 4; i++) begin
      set_btns(B_COLOR);
      @(negedge clk);
      check_eq($sformatf("t5_color[%0d]", i), current_color, exp_color[i]);
      set_btns(B_NONE);
      @(negedge clk);
    end
    set_btns(B_COLOR | B_DOWN);
    @(negedge clk);
    check_eq("t5_combo_color", current_color, 3);
    check_eq("t5_combo_y", cursor_y, 3);
    set_btns(B_NONE);
    @(negedge clk);
    check_eq("t5_combo_moved", moved, 1);
    set_btns(B_COLOR);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      check_eq($sformatf("t5_hold_color[%0d]", i), current_color, 1);
    end
    set_btns(B_NONE);
    @(negedge clk);
    tap(B_COLOR);
    check_eq("t5_color_pre_rst", current_color, 2);

    // reset during repeat
    tap(B_LEFT);
    check_eq("t6_x_pre", cursor_x, 2);
    set_btns(B_RIGHT);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check_eq($sformatf("t6_x[%0d]", i), cursor_x, exp_rep_x[i]);
    end
    reset = 1'b1;
    #1;
    check_eq("t6_rst_x", cursor_x, 0);
    check_eq("t6_rst_y", cursor_y, 0);
    check_eq("t6_rst_color", current_color, 1);
    check_eq("t6_rst_moved", moved, 0);
    @(negedge clk);
    check_eq("t6_rst_x_held", cursor_x, 0);
    reset = 1'b0;
    @(negedge clk);
    check_eq("t6_x_after_rst", cursor_x, 1);
    @(negedge clk);
    check_eq("t6_moved_after_rst", moved, 1);
    check_eq("t6_x_delay", cursor_x, 1);
    set_btns(B_NONE);
    @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
